add32_operand_loader: RTL and testbench

Byte-serial front end for the 32-bit carry-select adder (`part_4_top_module`). It collects two 32-bit operands from an 8-bit valid/ready input stream and drives them onto the adder's `a`/`b` inputs. It then registers the adder's combinational `sum` and presents it on a valid/ready output handshake. It is the stage directly upstream of the adder and also captures the adder's result.

---
 rtl/add32_operand_loader.sv | 89 ++++++++
 tb/tb_add32_operand_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/add32_operand_loader.sv
// Byte-serial operand loader and result register for the 32-bit carry-select adder.
// Optional macro ADD32_LOADER_MSB_FIRST_EN selects MSB-first byte placement.
module add32_operand_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] sum_in,
    output logic [31:0] out_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  dbg_state
);

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // a source keeps its data stable until then, and ready never depends on the same-cycle valid.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ADD    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] byte_cnt_q;
    logic [1:0] lane;
    logic       accept;

`ifdef ADD32_LOADER_MSB_FIRST_EN
    assign lane = 2'd3 - byte_cnt_q;
`else
    assign lane = byte_cnt_q;
`endif

    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt_q == 2'd3) state_d = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt_q == 2'd3) state_d = ADD;
            end
            ADD:     state_d = HOLD;
            HOLD: begin
                if (out_valid && out_ready) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD_A;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            out_sum    <= 32'd0;
            out_valid  <= 1'b0;
        end else begin
            // The counter wraps 3->0 on the byte that moves the FSM to the next operand.
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (state_q == LOAD_A) op_a[{lane, 3'b000} +: 8] <= in_data;
                else                   op_b[{lane, 3'b000} +: 8] <= in_data;
            end
            if (state_q == ADD) begin
                out_sum   <= sum_in;
                out_valid <= 1'b1;
            end
            if (state_q == HOLD && out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add32_operand_loader.sv
// Bench for add32_operand_loader: directed vector table, random transactions, reset corners.
// Models the downstream adder as a plain 32-bit sum of op_a and op_b.
module tb_add32_operand_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum_in;
    logic [31:0] out_sum;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    add32_operand_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .sum_in   (sum_in),
        .out_sum  (out_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dbg_state(dbg_state)
    );

    assign sum_in = op_a + op_b;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_sum;
        int          max_gap;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] v, input int k);
        int sh;
`ifdef ADD32_LOADER_MSB_FIRST_EN
        sh = 24 - 8 * k;
`else
        sh = 8 * k;
`endif
        return 8'(v >> sh);
    endfunction

    // driver: optional idle gap, then present one byte until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'(
        $urandom);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_sum, input int max_gap, input int hold);
        logic [31:0] got;
        exp_q.push_back(exp_sum);
        for (int k = 0; k < 4; k++) send_byte(byte_of(a, k), $urandom_range(0, max_gap));
        for (int k = 0; k < 4; k++) send_byte(byte_of(b, k), $urandom_range(0, max_gap));
        // ADD cycle: no result yet, no bytes accepted
        check("add_out_valid", {31'd0, out_valid}, 32'd0);
        check("add_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("op_a", op_a, a);
        check("op_b", op_b, b);
        got = exp_q.pop_front();
        check("out_sum", out_sum, got);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_sum", out_sum, got);
            check("bp_op_a", op_a, a);
            check("bp_op_b", op_b, b);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("xfer_out_valid", {31'd0, out_valid}, 32'd0);
        check("xfer_in_ready", {31'd0, in_ready}, 32'd1);
        check("xfer_out_sum", out_sum, got);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op_a"}, op_a, 32'd0);
        check({tag, "_op_b"}, op_b, 32'd0);
        check({tag, "_out_sum"}, out_sum, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        total     = 0;
        bad       = 0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;

        vecs[0] = '{32'h12345678, 32'h11111111, 32'h23456789, 0, 0};
        vecs[1] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 1};
        vecs[2] = '{32'h80000000, 32'h80000000, 32'h00000000, 0, 0};
        vecs[3] = '{32'h12345678, 32'h11111111, 32'h23456789, 3, 5};
        vecs[4] = '{32'h12345678, 32'h00000001, 32'h12345679, 1, 2};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0};

        // bytes offered during reset must be ignored
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        in_valid = 1'b0;
        rst      = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].max_gap, vecs[i].hold);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_txn(ra, rb, ra + rb, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // reset after 3 bytes of A, then a fresh transaction
        ra = 32'hCAFEBABE;
        for (int k = 0; k < 3; k++) send_byte(byte_of(ra, k), 0);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_mid_a");
        @(negedge clk);
        rst = 1'b0;
        run_txn(32'h0000FFFF, 32'h00000001, 32'h00010000, 1, 0);

        // reset while a result is pending in HOLD
        ra = 32'h01020304;
        rb = 32'h10203040;
        for (int k = 0; k < 4; k++) send_byte(byte_of(ra, k), 0);
        for (int k = 0; k < 4; k++) send_byte(byte_of(rb, k), 0);
        @(posedge clk);
        #1;
        check("pre_rst_sum", out_sum, 32'h11223344);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        run_txn(32'h00000005, 32'h00000007, 32'h0000000C, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
